// File: rtl/l2_tx_reader.sv
// l2_tx_reader
// Drains the four layer-2 result RAMs after layer_2 raises trmt and sends every
// 18-bit result to the UART byte transmitter. The order is address ascending,
// channel 0..3 within an address, and LSB-first bytes within a word.
// A one-cycle tx_done pulse follows the last byte. layer_2 uses it to clear its
// write pointer.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   trmt              level from layer_2; its rising edge starts a dump
//   din_0..din_3      RAM read data, valid one cycle after addr_rd
//   addr_rd           shared read address to all four RAMs
//   tx_busy           UART busy; rises the cycle after tx_start
//   tx_start          one-cycle launch pulse for tx_data
//   tx_data           byte to send, held from tx_start until tx_busy falls
//   tx_done           one-cycle pulse once the whole dump has left the UART
//   bsy               high from dump start through the tx_done cycle
//
// Handshake with the UART: a byte is launched only in a cycle where tx_busy is
// low. tx_start is high for exactly one cycle. tx_data is held unchanged until
// the UART drops tx_busy again.
module l2_tx_reader #(
    parameter int DEPTH          = 121,
    parameter int ADDR_W         = 7,
    parameter int BYTES_PER_WORD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [17:0]       din_0,
    input  logic [17:0]       din_1,
    input  logic [17:0]       din_2,
    input  logic [17:0]       din_3,
    output logic [ADDR_W-1:0] addr_rd,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              tx_done,
    output logic              bsy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_SEND,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic        trmt_q;
    logic [17:0] hold_q [4];
    logic [1:0]  ch_cnt;
    logic [1:0]  byte_cnt;
    logic        start;
    logic [17:0] word_sel;
    logic [7:0]  byte_sel;

    // A dump starts only on a rising edge of trmt. A level that stays high after
    // a dump therefore never retriggers one.
    assign start = trmt & ~trmt_q;

    always_comb begin
        word_sel = hold_q[ch_cnt];
        byte_sel = 8'h00;
        case (byte_cnt)
            2'd0:    byte_sel = word_sel[7:0];
            2'd1:    byte_sel = word_sel[15:8];
            default: byte_sel = {6'b0, word_sel[17:16]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            trmt_q   <= 1'b0;
            addr_rd  <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            tx_done  <= 1'b0;
            bsy      <= 1'b0;
            ch_cnt   <= 2'd0;
            byte_cnt <= 2'd0;
            for (int i = 0; i < 4; i++) hold_q[i] <= 18'h0;
        end else begin
            trmt_q   <= trmt;
            tx_start <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    bsy <= 1'b0;
                    if (start) begin
                        addr_rd <= '0;
                        bsy     <= 1'b1;
                        state   <= S_RD;
                    end
                end
                // One cycle of RAM read latency.
                S_RD: state <= S_LATCH;
                // Snapshot all four channels. Later RAM writes cannot
                // corrupt bytes already queued for sending.
                S_LATCH: begin
                    hold_q[0] <= din_0;
                    hold_q[1] <= din_1;
                    hold_q[2] <= din_2;
                    hold_q[3] <= din_3;
                    ch_cnt    <= 2'd0;
                    byte_cnt  <= 2'd0;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= byte_sel;
                        state    <= S_HOLD;
                    end
                end
                // tx_busy only rises the cycle after tx_start. Skip one
                // cycle so WAIT does not see the stale low level.
                S_HOLD: state <= S_WAIT;
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (byte_cnt < LAST_BYTE) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= S_SEND;
                        end else if (ch_cnt != 2'd3) begin
                            ch_cnt   <= ch_cnt + 2'd1;
                            byte_cnt <= 2'd0;
                            state    <= S_SEND;
                        end else if (addr_rd == LAST_ADDR) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            addr_rd <= addr_rd + ADDR_W'(1);
                            state   <= S_RD;
                        end
                    end
                end
                // tx_done is high during this cycle and bsy is still high.
                // bsy drops on the way back to IDLE.
                S_DONE: begin
                    bsy   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    a_start_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(tx_start && tx_done));
    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        addr_rd <= LAST_ADDR);
    a_byte_range: assert property (@(posedge clk) disable iff (!rst_n)
        byte_cnt <= LAST_BYTE);

endmodule
